// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, controller state encoding and result sizing for sys_ctrl_gen2.
package sys_ctrl_pkg;

    localparam logic [7:0] OP_WRITE   = 8'hAA;
    localparam logic [7:0] OP_READ    = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS = 8'hCC;
    localparam logic [7:0] OP_ALU     = 8'hDD;
    localparam logic [7:0] OP_BURST   = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_CNT,
        GET_A,
        GET_B,
        GET_FUN,
        WR_A,
        WR_B,
        RD_REQ,
        RD_WAIT,
        ALU_REQ,
        ALU_WAIT,
        TX_SEND,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_e;

    // Number of TX bytes needed to carry an ALU result of out_w bits.
    function automatic int unsigned out_bytes(input int unsigned out_w, input int unsigned data_w);
        return (out_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter for in-frame timeout; saturates at the limit, inert when the limit is 0.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    assign expired_c = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sys_ctrl_gen2.sv
// Second-generation system controller: decodes UART command frames into register,
// burst-read and ALU transactions and streams results back over UART TX.
module sys_ctrl_gen2
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned ALU_FUN_WIDTH  = 4,
    parameter int unsigned ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_data_valid,
    input  logic                     TX_Busy,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_EN,
    output logic                     CLK_DIV_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_DATA_VALID,
    output logic                     FRAME_ERR
);

    localparam int unsigned OUT_BYTES = out_bytes(ALU_OUT_WIDTH, DATA_WIDTH);
    localparam int unsigned SHIFT_W   = OUT_BYTES * DATA_WIDTH;
    localparam int unsigned CNT_W     = ((DATA_WIDTH + 1) > $clog2(OUT_BYTES + 1))
                                        ? (DATA_WIDTH + 1) : $clog2(OUT_BYTES + 1);
    // A burst count byte of zero means a full 2^DATA_WIDTH bytes.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << DATA_WIDTH;

    state_e                   state;
    logic [DATA_WIDTH-1:0]    op_q;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic [CNT_W-1:0]         remaining_q;
    logic                     burst_q;
    logic                     in_get_c;
    logic                     timeout_c;

    assign in_get_c = state inside {GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN};

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .clear    (RX_data_valid || !in_get_c),
        .enable   (in_get_c),
        .expired_c(timeout_c)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            addr_q        <= '0;
            shift_q       <= '0;
            remaining_q   <= '0;
            burst_q       <= 1'b0;
            WrData        <= '0;
            Address       <= '0;
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            ALU_FUN       <= '0;
            ALU_EN        <= 1'b0;
            CLK_EN        <= 1'b0;
            CLK_DIV_EN    <= 1'b0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            FRAME_ERR     <= 1'b0;
        end else begin
            WrEn          <= 1'b0;
            RdEn          <= 1'b0;
            ALU_EN        <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            FRAME_ERR     <= 1'b0;
            CLK_DIV_EN    <= 1'b1;

            case (state)
                IDLE: begin
                    if (RX_data_valid) begin
                        op_q <= RX_P_DATA;
                        if (RX_P_DATA == DATA_WIDTH'(OP_WRITE) || RX_P_DATA == DATA_WIDTH'(OP_READ) ||
                            RX_P_DATA == DATA_WIDTH'(OP_BURST)) begin
                            state <= GET_ADDR;
                        end else if (RX_P_DATA == DATA_WIDTH'(OP_ALU_OPS)) begin
                            state <= GET_A;
                        end else if (RX_P_DATA == DATA_WIDTH'(OP_ALU)) begin
                            state <= GET_FUN;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                end
                GET_ADDR: begin
                    if (RX_data_valid) begin
                        addr_q <= ADDRESS_WIDTH'(RX_P_DATA);
                        if (op_q == DATA_WIDTH'(OP_WRITE)) begin
                            state <= GET_DATA;
                        end else if (op_q == DATA_WIDTH'(OP_READ)) begin
                            Address     <= ADDRESS_WIDTH'(RX_P_DATA);
                            RdEn        <= 1'b1;
                            remaining_q <= CNT_W'(1);
                            burst_q     <= 1'b0;
                            state       <= RD_REQ;
                        end else begin
                            state <= GET_CNT;
                        end
                    end
                end
                GET_DATA: begin
                    if (RX_data_valid) begin
                        Address <= addr_q;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                GET_CNT: begin
                    if (RX_data_valid) begin
                        remaining_q <= (RX_P_DATA == '0) ? CNT_FULL : CNT_W'(RX_P_DATA);
                        burst_q     <= 1'b1;
                        Address     <= addr_q;
                        RdEn        <= 1'b1;
                        state       <= RD_REQ;
                    end
                end
                GET_A: begin
                    if (RX_data_valid) begin
                        a_q   <= RX_P_DATA;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (RX_data_valid) begin
                        b_q   <= RX_P_DATA;
                        state <= GET_FUN;
                    end
                end
                GET_FUN: begin
                    if (RX_data_valid) begin
                        ALU_FUN <= ALU_FUN_WIDTH'(RX_P_DATA);
                        if (op_q == DATA_WIDTH'(OP_ALU_OPS)) begin
                            Address <= '0;
                            WrData  <= a_q;
                            WrEn    <= 1'b1;
                            state   <= WR_A;
                        end else begin
                            ALU_EN <= 1'b1;
                            CLK_EN <= 1'b1;
                            state  <= ALU_REQ;
                        end
                    end
                end
                WR_A: begin
                    Address <= ADDRESS_WIDTH'(1);
                    WrData  <= b_q;
                    WrEn    <= 1'b1;
                    state   <= WR_B;
                end
                WR_B: begin
                    ALU_EN <= 1'b1;
                    CLK_EN <= 1'b1;
                    state  <= ALU_REQ;
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    if (RdData_Valid) begin
                        shift_q <= SHIFT_W'(RdData);
                        state   <= TX_SEND;
                    end
                end
                ALU_REQ: state <= ALU_WAIT;
                ALU_WAIT: begin
                    if (ALU_OUT_VALID) begin
                        shift_q     <= SHIFT_W'(ALU_OUT);
                        CLK_EN      <= 1'b0;
                        remaining_q <= CNT_W'(OUT_BYTES);
                        burst_q     <= 1'b0;
                        state       <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!TX_Busy) begin
                        TX_P_DATA     <= shift_q[DATA_WIDTH-1:0];
                        TX_DATA_VALID <= 1'b1;
                        state         <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (TX_Busy) begin
                        state <= TX_WAIT_LO;
                    end
                end
                TX_WAIT_LO: begin
                    // Byte fully shifted out: next burst address, next result byte, or done.
                    if (!TX_Busy) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state <= IDLE;
                        end else if (burst_q) begin
                            addr_q  <= addr_q + ADDRESS_WIDTH'(1);
                            Address <= addr_q + ADDRESS_WIDTH'(1);
                            RdEn    <= 1'b1;
                            state   <= RD_REQ;
                        end else begin
                            shift_q <= shift_q >> DATA_WIDTH;
                            state   <= TX_SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Silence inside a frame abandons it; a byte arriving on the same cycle takes priority.
            if (in_get_c && !RX_data_valid && timeout_c) begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Scoreboard bench for sys_ctrl_gen2 with register-file, ALU and UART TX models around the DUT.
module tb_sys_ctrl_gen2;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_ALU = 2;
    localparam int EV_TX  = 3;
    localparam int EV_ERR = 4;

    typedef struct {
        int kind;
        int a;
        int d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_data_valid = 1'b0;
    logic        TX_Busy = 1'b0;
    logic [7:0]  RdData = 8'h00;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VALID = 1'b0;
    logic [7:0]  WrData;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_EN;
    logic        CLK_DIV_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        FRAME_ERR;

    bit [7:0] rf_mem   [16];
    bit [7:0] ref_regs [16];

    sys_ctrl_gen2 #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4),
        .ALU_FUN_WIDTH (4),
        .ALU_OUT_WIDTH (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_data_valid(RX_data_valid),
        .TX_Busy      (TX_Busy),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_VALID(ALU_OUT_VALID),
        .WrData       (WrData),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .ALU_FUN      (ALU_FUN),
        .ALU_EN       (ALU_EN),
        .CLK_EN       (CLK_EN),
        .CLK_DIV_EN   (CLK_DIV_EN),
        .TX_P_DATA    (TX_P_DATA),
        .TX_DATA_VALID(TX_DATA_VALID),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic string ev_name(input int k);
        case (k)
            EV_WR:   return "WR";
            EV_RD:   return "RD";
            EV_ALU:  return "ALU";
            EV_TX:   return "TX";
            EV_ERR:  return "ERR";
            default: return "?";
        endcase
    endfunction

    // ALU behaviour: add, sub, mul, and, or, xor, otherwise concatenate operands.
    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return 16'(a & b);
            4'd4:    return 16'(a | b);
            4'd5:    return 16'(a ^ b);
            default: return {a, b};
        endcase
    endfunction

    task automatic expect_evt(input int kind, input int a, input int d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got a=%0d d=0x%0h, expected no event", ev_name(kind), a, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.a != a || e.d != d) begin
            errors++;
            $display("FAIL event: got %s a=%0d d=0x%0h, expected %s a=%0d d=0x%0h",
                     ev_name(kind), a, d, ev_name(e.kind), e.a, e.d);
        end
    endtask

    // Monitor: every strobe the DUT raises is matched against the scoreboard in order.
    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn)          expect_evt(EV_WR, int'(Address), int'(WrData));
            if (RdEn)          expect_evt(EV_RD, int'(Address), 0);
            if (ALU_EN) begin
                expect_evt(EV_ALU, 0, int'(ALU_FUN));
                checks++;
                if (CLK_EN !== 1'b1) begin
                    errors++;
                    $display("FAIL clk_en_at_alu_en: got %b, expected 1", CLK_EN);
                end
            end
            if (TX_DATA_VALID) expect_evt(EV_TX, 0, int'(TX_P_DATA));
            if (FRAME_ERR)     expect_evt(EV_ERR, 0, 0);
        end
    end

    // Register file model: writes land immediately, reads answer one cycle after RdEn.
    logic       rd_pend = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    always @(negedge CLK) begin
        RdData_Valid = 1'b0;
        if (rd_pend) begin
            RdData       = rf_mem[rd_addr];
            RdData_Valid = 1'b1;
            rd_pend      = 1'b0;
        end
        if (RST && WrEn) rf_mem[Address] = WrData;
        if (RST && RdEn) begin
            rd_pend = 1'b1;
            rd_addr = Address;
        end
    end

    // ALU model: result one cycle after ALU_EN, operands from registers 0 and 1.
    logic       alu_pend = 1'b0;
    logic [3:0] alu_f = 4'h0;
    always @(negedge CLK) begin
        ALU_OUT_VALID = 1'b0;
        if (alu_pend) begin
            ALU_OUT       = alu_calc(rf_mem[0], rf_mem[1], alu_f);
            ALU_OUT_VALID = 1'b1;
            alu_pend      = 1'b0;
        end
        if (RST && ALU_EN) begin
            alu_pend = 1'b1;
            alu_f    = ALU_FUN;
        end
    end

    // UART TX model: busy rises 1-2 cycles after a request and stays up 2-6 cycles.
    int tx_dly = 0;
    int tx_hold = 0;
    always @(negedge CLK) begin
        if (RST && TX_DATA_VALID) begin
            checks++;
            if (TX_Busy) begin
                errors++;
                $display("FAIL tx_overlap: TX_DATA_VALID=1 with TX_Busy=%b, expected TX_Busy=0", TX_Busy);
            end
        end
        if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) TX_Busy = 1'b0;
        end else if (tx_dly > 0) begin
            tx_dly--;
            if (tx_dly == 0) begin
                TX_Busy = 1'b1;
                tx_hold = int'($urandom_range(2, 6));
            end
        end
        if (TX_DATA_VALID) tx_dly = int'($urandom_range(1, 2));
    end

    task automatic push(input int kind, input int a, input int d);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        RX_P_DATA     = b;
        RX_data_valid = 1'b1;
        @(negedge CLK);
        RX_data_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge CLK);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        push(EV_WR, int'(addr[3:0]), int'(data));
        ref_regs[addr[3:0]] = data;
        send_byte(8'hAA, 3);
        send_byte(addr, 3);
        send_byte(data, 3);
    endtask

    task automatic do_read(input logic [7:0] addr);
        push(EV_RD, int'(addr[3:0]), 0);
        push(EV_TX, 0, int'(ref_regs[addr[3:0]]));
        send_byte(8'hBB, 3);
        send_byte(addr, 3);
    endtask

    task automatic push_alu(input logic [7:0] f);
        logic [15:0] r;
        r = alu_calc(ref_regs[0], ref_regs[1], f[3:0]);
        push(EV_ALU, 0, int'(f[3:0]));
        push(EV_TX, 0, int'(r[7:0]));
        push(EV_TX, 0, int'(r[15:8]));
    endtask

    task automatic do_alu_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        push(EV_WR, 0, int'(a));
        push(EV_WR, 1, int'(b));
        ref_regs[0] = a;
        ref_regs[1] = b;
        push_alu(f);
        send_byte(8'hCC, 3);
        send_byte(a, 3);
        send_byte(b, 3);
        send_byte(f, 3);
    endtask

    task automatic do_alu(input logic [7:0] f);
        push_alu(f);
        send_byte(8'hDD, 3);
        send_byte(f, 3);
    endtask

    task automatic do_burst(input logic [7:0] addr, input logic [7:0] cnt);
        int n;
        int ad;
        n = (cnt == 8'h00) ? 256 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            ad = (int'(addr[3:0]) + i) % 16;
            push(EV_RD, ad, 0);
            push(EV_TX, 0, int'(ref_regs[ad]));
        end
        send_byte(8'hEE, 3);
        send_byte(addr, 3);
        send_byte(cnt, 3);
    endtask

    task automatic do_bad(input logic [7:0] op);
        push(EV_ERR, 0, 0);
        send_byte(op, 3);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_pending: got %0d events outstanding after %0d cycles, expected 0", name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (12) @(negedge CLK);
        checks++;
        if (CLK_EN !== 1'b0) begin
            errors++;
            $display("FAIL %s_clk_en: got %b, expected 0", name, CLK_EN);
        end
    endtask

    task automatic check_zero(input string name);
        logic [30:0] v;
        v = {WrData, Address, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_EN, CLK_DIV_EN, TX_P_DATA, TX_DATA_VALID, FRAME_ERR};
        checks++;
        if (v !== 31'h0) begin
            errors++;
            $display("FAIL %s: got outputs 0x%0h, expected 0", name, v);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int kind;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] f;
        logic [7:0] op;

        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b1;
        checks++;
        if (CLK_DIV_EN !== 1'b0) begin
            errors++;
            $display("FAIL div_en_before_clock: got %b, expected 0", CLK_DIV_EN);
        end
        @(negedge CLK);
        checks++;
        if (CLK_DIV_EN !== 1'b1) begin
            errors++;
            $display("FAIL div_en_after_clock: got %b, expected 1", CLK_DIV_EN);
        end

        do_write(8'h05, 8'h3C);          wait_done("write_5");
        do_read(8'h05);                  wait_done("read_5");
        do_alu_ops(8'h0A, 8'h14, 8'h00); wait_done("alu_add");
        do_alu(8'h02);                   wait_done("alu_mul");
        do_write(8'h0E, 8'h11);          wait_done("write_14");
        do_write(8'h0F, 8'h22);          wait_done("write_15");
        do_write(8'h00, 8'h33);          wait_done("write_0");
        do_burst(8'h0E, 8'h03);          wait_done("burst_wrap");

        // Partial write abandoned by silence must raise FRAME_ERR and write nothing.
        push(EV_ERR, 0, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h05, 0);
        n = 0;
        while (FRAME_ERR !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n < 16 || n > 18) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, expected 16..18", n);
        end
        wait_done("timeout");
        do_read(8'h05);                  wait_done("read_after_timeout");
        do_bad(8'h55);                   wait_done("bad_opcode");
        do_burst(8'h03, 8'h00);          wait_done("burst_256");

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 5));
            a    = 8'($urandom);
            d    = 8'($urandom);
            f    = 8'($urandom);
            case (kind)
                0: do_write(a, d);
                1: do_read(a);
                2: do_alu_ops(a, d, f);
                3: do_alu(f);
                4: do_burst(a, 8'($urandom_range(1, 4)));
                default: begin
                    op = 8'($urandom);
                    while (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}) op = 8'($urandom);
                    do_bad(op);
                end
            endcase
            wait_done("random");
        end

        // Reset in the middle of a burst clears every output at once.
        do_burst(8'h02, 8'h08);
        n = 0;
        while (exp_q.size() > 12 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        #2 RST = 1'b0;
        #1 check_zero("reset_mid_burst");
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (12) @(negedge CLK);
        checks++;
        if (CLK_DIV_EN !== 1'b1) begin
            errors++;
            $display("FAIL div_en_after_rerelease: got %b, expected 1", CLK_DIV_EN);
        end
        do_read(8'h0E);                  wait_done("read_after_reset");
        do_write(8'h07, 8'h5A);          wait_done("write_after_reset");
        do_read(8'h07);                  wait_done("read_back_7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
